// File: rtl/fcs_check_par.sv
// Streaming Ethernet-style FCS checker: CRC-32 over DATA_W bits per cycle, residue test at end of frame,
// runt detection and saturating frame/error statistics.
module fcs_check_par #(
   parameter int DATA_W   = 8,
   parameter int CNT_W    = 16,
   parameter int MIN_BITS = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic              start_of_frame,
   input  logic              end_of_frame,
   input  logic [DATA_W-1:0] data_in,
   output logic              fcs_valid,
   output logic              fcs_error,
   output logic              runt,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  err_cnt
);

   localparam int BCNT_W = ($clog2(MIN_BITS + 1) + 1 > 16) ? $clog2(MIN_BITS + 1) + 1 : 16;

   localparam logic [31:0]       CRC_POLY    = 32'h04C1_1DB7;
   localparam logic [31:0]       CRC_SEED    = 32'hFFFF_FFFF;
   localparam logic [31:0]       CRC_RESIDUE = 32'hC704_DD7B;
   localparam logic [BCNT_W-1:0] MIN_LEN     = BCNT_W'(MIN_BITS);
   localparam logic [BCNT_W-1:0] STEP        = BCNT_W'(DATA_W);
   localparam logic [BCNT_W-1:0] BCNT_MAX    = {BCNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FRAME = 1'b1
   } state_t;

   // Serial MSB-out CRC unrolled over one word; word[0] is shifted in first.
   function automatic logic [31:0] crc_update(input logic [31:0] crc_in, input logic [DATA_W-1:0] word);
      logic [31:0] c;
      logic        fb;
      c = crc_in;
      for (int i = 0; i < DATA_W; i++) begin
         fb = c[31] ^ word[i];
         c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
      end
      return c;
   endfunction

   function automatic logic [BCNT_W-1:0] bits_add(input logic [BCNT_W-1:0] cnt);
      logic [BCNT_W-1:0] sum;
      if (cnt > BCNT_MAX - STEP) begin
         sum = BCNT_MAX;
      end else begin
         sum = cnt + STEP;
      end
      return sum;
   endfunction

   state_t            state_r;
   logic [31:0]       crc_r;
   logic [BCNT_W-1:0] bit_cnt_r;

   logic              seed_s;
   logic              take_s;
   logic              last_s;
   logic              runt_s;
   logic              bad_s;
   logic [31:0]       crc_nxt_s;
   logic [BCNT_W-1:0] bits_nxt_s;

   // Decide whether the bus word is consumed and what CRC/length it produces;
   // a start word always reseeds, which also aborts any frame in progress.
   always_comb begin
      seed_s = valid_in & start_of_frame;
      case (state_r)
         IDLE:    take_s = seed_s;
         FRAME:   take_s = valid_in;
         default: take_s = 1'b0;
      endcase
      if (seed_s) begin
         crc_nxt_s  = crc_update(CRC_SEED, data_in);
         bits_nxt_s = STEP;
      end else begin
         crc_nxt_s  = crc_update(crc_r, data_in);
         bits_nxt_s = bits_add(bit_cnt_r);
      end
      last_s = take_s & end_of_frame;
      runt_s = (bits_nxt_s < MIN_LEN);
      bad_s  = runt_s | (crc_nxt_s != CRC_RESIDUE);
   end

   // Frame state, running CRC, bit count and the registered result pulse
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r   <= IDLE;
         crc_r     <= CRC_SEED;
         bit_cnt_r <= {BCNT_W{1'b0}};
         fcs_valid <= 1'b0;
         fcs_error <= 1'b0;
         runt      <= 1'b0;
      end else begin
         fcs_valid <= last_s;
         fcs_error <= last_s & bad_s;
         runt      <= last_s & runt_s;
         if (take_s) begin
            crc_r     <= crc_nxt_s;
            bit_cnt_r <= bits_nxt_s;
            state_r   <= last_s ? IDLE : FRAME;
         end
      end
   end

   // Saturating statistics, updated in the same cycle the result is registered
   always_ff @(posedge clk) begin
      if (!reset) begin
         frame_cnt <= {CNT_W{1'b0}};
         err_cnt   <= {CNT_W{1'b0}};
      end else if (last_s) begin
         if (frame_cnt != CNT_MAX) begin
            frame_cnt <= frame_cnt + CNT_ONE;
         end
         if (bad_s && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: doc/fcs_check_par.md
FCS_CHECK_PAR -- requirements
Module: fcs_check_par

Interface
REQ-001 Parameter DATA_W, default 8, bits accepted per valid cycle; legal values 1, 2, 4, 8, 16, 32.
REQ-002 Parameter CNT_W, default 16, width of the frame and error statistics counters.
REQ-003 Parameter MIN_BITS, default 64, minimum legal frame length in bits, FCS included; must be a multiple of DATA_W.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 valid_in  input  1  qualifies data_in, start_of_frame and end_of_frame; all are ignored when low.
REQ-007 start_of_frame  input  1  word holds the first bits of a frame.
REQ-008 end_of_frame  input  1  word holds the last bits of the frame (last FCS bits).
REQ-009 data_in  input  DATA_W  data word; data_in[0] is the earliest bit on the wire.
REQ-010 fcs_valid  output  1  one-cycle pulse: a check result is present.
REQ-011 fcs_error  output  1  CRC residue mismatch or runt; meaningful only while fcs_valid=1, else 0.
REQ-012 runt  output  1  frame shorter than MIN_BITS; meaningful only while fcs_valid=1, else 0.
REQ-013 frame_cnt  output  CNT_W  number of completed frames, saturating.
REQ-014 err_cnt  output  CNT_W  number of completed frames with fcs_error=1, saturating.

Function
REQ-015 CRC-32, polynomial 0x04C11DB7, 32-bit register, MSB-out form: per bit, fb = crc[31] ^ bit; crc = (crc << 1) ^ (fb ? 0x04C11DB7 : 0).
REQ-016 One accepted word is DATA_W serial steps in one cycle, data_in[0] first, data_in[DATA_W-1] last.
REQ-017 All frame bits, FCS included, are fed to the CRC uncomplemented.
REQ-018 States: IDLE, FRAME.
REQ-019 IDLE: valid_in & start_of_frame -> FRAME; CRC seeded with 0xFFFFFFFF, then that word is processed; bit counter = DATA_W.
REQ-020 IDLE: valid_in without start_of_frame -> word discarded, no output.
REQ-021 FRAME: each valid_in word updates the CRC and adds DATA_W to a saturating bit counter of at least 16 bits.
REQ-022 valid_in=0 -> CRC, counter and state hold, in any state.
REQ-023 End of frame: on the word accepted with end_of_frame=1, after it is processed, compare CRC to 0xC704DD7B and return to IDLE.
REQ-024 fcs_valid pulses exactly one cycle after the end_of_frame word; latency is 1 cycle.
REQ-025 runt=1 if the bit count including the end_of_frame word is < MIN_BITS.
REQ-026 fcs_error=1 if runt=1 or the CRC differs from 0xC704DD7B.
REQ-027 start_of_frame and end_of_frame in the same word: a one-word frame, checked per REQ-023 to REQ-026 (runt unless DATA_W >= MIN_BITS).
REQ-028 start_of_frame in FRAME without end_of_frame: current frame aborted (no pulse, no count change), CRC reseeded, new frame starts with this word.
REQ-029 start_of_frame and end_of_frame together in FRAME: abort per REQ-028, then check a one-word frame per REQ-027.
REQ-030 frame_cnt increments by 1 per fcs_valid pulse; err_cnt also increments when fcs_error=1; both hold at 2^CNT_W-1.
REQ-031 Back-to-back frames (start_of_frame on the cycle after end_of_frame) are accepted with no dead cycle.

Reset
REQ-032 reset=0 at a clock edge: state IDLE; CRC 0xFFFFFFFF; bit counter 0; fcs_valid, fcs_error, runt 0; frame_cnt, err_cnt 0.
REQ-033 Reset mid-frame discards the frame; no pulse is produced for it.

Verification
REQ-034 DATA_W=8, bytes 31 32 33 34 35 36 37 38 39 26 39 F4 CB, contiguous -> one cycle after the 0xCB word: fcs_valid=1, fcs_error=0, runt=0; frame_cnt=1, err_cnt=0.
REQ-035 Same frame with data_in[3] of byte 0x35 inverted -> fcs_valid=1, fcs_error=1, runt=0; err_cnt=1.
REQ-036 Same good frame with valid_in low for 3 cycles after every second byte, then a DATA_W=1 instance fed the same bits LSB-first -> both report fcs_error=0.
REQ-037 DATA_W=8, 4-byte frame 00 00 00 00 -> runt=1, fcs_error=1.
REQ-038 Good frame interrupted after 5 bytes by start_of_frame, then the full good frame -> exactly one pulse with fcs_error=0, frame_cnt=1.
REQ-039 reset=0 for one cycle after 6 bytes, then the full good frame -> a single pulse with fcs_error=0, frame_cnt=1.
REQ-040 CNT_W=2, five bad frames -> err_cnt=3 and frame_cnt=3 after the fifth frame (both saturate).
